// File: rtl/synchronizer_2ff_pkg.sv
// rtl/synchronizer_2ff_pkg.sv - shared constants for the multi-stage bit synchronizer
package synchronizer_2ff_pkg;

   // Legal flop depth per lane; two is the minimum for metastability settling.
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Per-lane default reset level; the top replicates it across DATA_WIDTH.
   localparam logic SYNC_RESET_BIT = 1'b0;

   // True when a requested chain depth is within the supported range.
   function automatic bit stages_legal(input int n);
      return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/sync_bit_chain.sv
// rtl/sync_bit_chain.sv - single-lane synchronizer flop chain with reset value
module sync_bit_chain
   import synchronizer_2ff_pkg::*;
#(
   parameter int   NUM_STAGES = SYNC_STAGES_MIN,
   parameter logic RESET_VAL  = SYNC_RESET_BIT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic data_i,
   output logic sync_o
);

   // Depth outside 2..4 is a configuration error caught at elaboration.
   if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
      $error("sync_bit_chain: NUM_STAGES must be within 2..4");
   end

   // Kept together and un-retimed so the first stage gets a full period to resolve.
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO", DONT_TOUCH = "TRUE" *)
   logic [NUM_STAGES-1:0] chain;

   // Shift the foreign-domain bit toward the output; reset flushes every stage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chain <= {NUM_STAGES{RESET_VAL}};
      end else begin
         chain <= {chain[NUM_STAGES-2:0], data_i};
      end
   end

   assign sync_o = chain[NUM_STAGES-1];

endmodule

// File: rtl/synchronizer_2ff.sv
// rtl/synchronizer_2ff.sv - multi-lane flop-chain synchronizer with edge pulses
module synchronizer_2ff
   import synchronizer_2ff_pkg::*;
#(
   parameter int                    DATA_WIDTH = 1,
   parameter int                    NUM_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{SYNC_RESET_BIT}}
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data_sync_o,
   output logic [DATA_WIDTH-1:0] rise_o,
   output logic [DATA_WIDTH-1:0] fall_o,
   output logic                  changed_o
);

   logic [DATA_WIDTH-1:0] sync_q;
   logic [DATA_WIDTH-1:0] history_q;

   // Lanes are independent; multi-bit values are only safe when Gray-coded upstream.
   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_lane
      sync_bit_chain #(
         .NUM_STAGES (NUM_STAGES),
         .RESET_VAL  (RESET_VAL[k])
      ) u_chain (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .data_i (data_i[k]),
         .sync_o (sync_q[k])
      );
   end

   // Previous synchronized value; resets alongside the chains so reset never emits a pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         history_q <= RESET_VAL;
      end else begin
         history_q <= sync_q;
      end
   end

   assign data_sync_o = sync_q;
   assign rise_o      = sync_q & ~history_q;
   assign fall_o      = ~sync_q & history_q;
   assign changed_o   = |(rise_o | fall_o);

endmodule

// File: tb/tb_synchronizer_2ff.sv
// tb/tb_synchronizer_2ff.sv - scoreboard bench for the flop-chain synchronizer
`timescale 1ns/100ps
module tb_synchronizer_2ff;

   typedef struct {
      int         edge_n;
      logic [3:0] rise;
      logic [3:0] fall;
   } evt_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_a;
   logic [3:0] data_b;
   logic       sync_a, rise_a, fall_a, chg_a;
   logic [3:0] sync_b, rise_b, fall_b;
   logic       chg_b;

   int checks = 0;
   int errors = 0;

   // Receiving clock, 5 ns period.
   always #2.5 clk = ~clk;

   synchronizer_2ff dut_a (
      .clk_i       (clk),
      .rst_i       (rst),
      .data_i      (data_a),
      .data_sync_o (sync_a),
      .rise_o      (rise_a),
      .fall_o      (fall_a),
      .changed_o   (chg_a)
   );

   synchronizer_2ff #(
      .DATA_WIDTH (4),
      .NUM_STAGES (3)
   ) dut_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .data_i      (data_b),
      .data_sync_o (sync_b),
      .rise_o      (rise_b),
      .fall_o      (fall_b),
      .changed_o   (chg_b)
   );

   // Reference model state: input samples per edge, delayed by the chain depth.
   logic [3:0] hist [2][4];
   logic [3:0] prev_exp [2];
   int         since_rst [2];
   logic [3:0] sync_q [2][$];
   evt_t       evt_q [2][$];
   int         edge_n = 0;
   bit         armed = 1'b0;

   function automatic int stages(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   // Model: output equals the input seen N edges ago, or reset value if reset was within those edges.
   initial begin
      logic [3:0] din [2];
      logic [3:0] exp_v;
      evt_t       e;
      forever begin
         @(posedge clk);
         din[0] = {3'b000, data_a};
         din[1] = data_b;
         if (rst) armed = 1'b1;
         edge_n++;
         if (armed) begin
            for (int d = 0; d < 2; d++) begin
               for (int i = 3; i > 0; i--) hist[d][i] = hist[d][i-1];
               hist[d][0] = din[d];
               if (rst) since_rst[d] = 0;
               else     since_rst[d]++;
               exp_v = (rst || since_rst[d] < stages(d)) ? 4'h0 : hist[d][stages(d)-1];
               sync_q[d].push_back(exp_v);
               if (!rst && exp_v != prev_exp[d]) begin
                  e.edge_n = edge_n;
                  e.rise   = exp_v & ~prev_exp[d];
                  e.fall   = ~exp_v & prev_exp[d];
                  evt_q[d].push_back(e);
               end
               prev_exp[d] = exp_v;
            end
         end
      end
   end

   task automatic check_lane(input int d, input logic [3:0] s, input logic [3:0] r,
                             input logic [3:0] f, input logic c);
      logic [3:0] es;
      evt_t       e;
      checks++;
      if (sync_q[d].size() == 0) begin
         errors++;
         $display("FAIL sync_q_empty dut%0d edge %0d", d, edge_n);
      end else begin
         es = sync_q[d].pop_front();
         if (s !== es) begin
            errors++;
            $display("FAIL data_sync dut%0d edge %0d: got %h expected %h", d, edge_n, s, es);
         end
      end
      checks++;
      if (c === 1'b1) begin
         if (evt_q[d].size() == 0 || evt_q[d][0].edge_n != edge_n) begin
            errors++;
            $display("FAIL spurious_pulse dut%0d edge %0d: rise %h fall %h expected none", d, edge_n, r, f);
         end else begin
            e = evt_q[d].pop_front();
            if (r !== e.rise || f !== e.fall) begin
               errors++;
               $display("FAIL pulse dut%0d edge %0d: rise %h fall %h expected rise %h fall %h",
                        d, edge_n, r, f, e.rise, e.fall);
            end
         end
      end else begin
         if (r !== 4'h0 || f !== 4'h0 || c !== 1'b0) begin
            errors++;
            $display("FAIL quiet dut%0d edge %0d: rise %h fall %h changed %b expected 0", d, edge_n, r, f, c);
         end else if (evt_q[d].size() != 0 && evt_q[d][0].edge_n <= edge_n) begin
            errors++;
            $display("FAIL missed_pulse dut%0d edge %0d: got none expected rise %h fall %h",
                     d, edge_n, evt_q[d][0].rise, evt_q[d][0].fall);
            void'(evt_q[d].pop_front());
         end
      end
   endtask

   // Monitor: samples outputs on the falling edge and retires scoreboard entries.
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            check_lane(0, {3'b000, sync_a}, {3'b000, rise_a}, {3'b000, fall_a}, chg_a);
            check_lane(1, sync_b, rise_b, fall_b, chg_b);
         end
      end
   end

   task automatic expect_eq(input string name, input logic [3:0] got, input logic [3:0] exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp_v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus: directed scenarios then randomized transfers.
   initial begin
      rst    = 1'b1;
      data_a = 1'b1;
      data_b = 4'hF;

      // Reset held three cycles with inputs high.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         expect_eq("reset_sync_a", {3'b000, sync_a}, 4'h0);
         expect_eq("reset_pulse_a", {2'b00, rise_a, fall_a}, 4'h0);
         expect_eq("reset_sync_b", sync_b, 4'h0);
      end
      rst    = 1'b0;
      data_a = 1'b0;
      data_b = 4'h0;
      repeat (3) @(posedge clk);

      // Latency: change mid-period, output after exactly two edges.
      @(posedge clk); #2;
      data_a = 1'b1;
      @(posedge clk); #1;
      expect_eq("lat_edge1_sync", {3'b000, sync_a}, 4'h0);
      @(posedge clk); #1;
      expect_eq("lat_edge2_sync", {3'b000, sync_a}, 4'h1);
      expect_eq("lat_edge2_rise", {3'b000, rise_a}, 4'h1);
      expect_eq("lat_edge2_changed", {3'b000, chg_a}, 4'h1);
      @(posedge clk); #1;
      expect_eq("lat_edge3_rise", {3'b000, rise_a}, 4'h0);

      // Glitch shorter than a period between edges.
      data_a = 1'b0;
      repeat (4) @(posedge clk);
      #1 data_a = 1'b1;
      #2 data_a = 1'b0;
      repeat (4) @(posedge clk); #1;
      expect_eq("glitch_sync", {3'b000, sync_a}, 4'h0);

      // Gray sequence on the four-lane, three-stage instance.
      for (int i = 0; i < 4; i++) begin
         logic [3:0] g;
         g = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0001 : (i == 2) ? 4'b0011 : 4'b0010;
         @(posedge clk); #1;
         data_b = g;
         repeat (2) @(posedge clk); #1;
         if (i != 0) expect_eq("gray_not_yet", sync_b ^ g, (i == 1) ? 4'b0001 : (i == 2) ? 4'b0010 : 4'b0001);
         @(posedge clk); #1;
         expect_eq("gray_latency3", sync_b, g);
      end

      // Reset while a rising value is in flight.
      @(posedge clk); #1;
      data_a = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      expect_eq("midreset_sync", {3'b000, sync_a}, 4'h0);
      expect_eq("midreset_rise", {3'b000, rise_a}, 4'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      expect_eq("midreset_edge1_rise", {3'b000, rise_a}, 4'h0);
      @(posedge clk); #1;
      expect_eq("midreset_edge2_sync", {3'b000, sync_a}, 4'h1);
      expect_eq("midreset_edge2_rise", {3'b000, rise_a}, 4'h1);
      repeat (4) @(posedge clk);

      // 100 random bits, each held four receiving periods with random skew.
      for (int i = 0; i < 100; i++) begin
         logic b;
         int   skew;
         int   idx;
         b    = 1'($urandom_range(0, 1));
         skew = $urandom_range(1, 49);
         idx  = $urandom_range(0, 3);
         @(posedge clk); #(skew * 0.1);
         data_a      = b;
         data_b[idx] = ~data_b[idx];
         repeat (3) @(posedge clk); #0.5;
         expect_eq("random_bit_a", {3'b000, sync_a}, {3'b000, b});
         expect_eq("random_gray_b", sync_b, data_b);
      end

      repeat (6) @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (evt_q[d].size() != 0) begin
            errors++;
            $display("FAIL leftover_pulses dut%0d: got %0d pending expected 0", d, evt_q[d].size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
